branch_target_buffer: RTL and testbench

Two-way set-associative branch target buffer in the IF stage, next to the global branch predictor. Each cycle it looks up the fetch PC and returns a cached branch target on a hit. It combines that hit with the predictor's taken bit to produce the predicted next fetch PC. In writeback it learns the targets of resolved taken branches, indexing by the branch PC recovered from the writeback PC+2.

---
 rtl/branch_target_buffer.sv | 122 ++++++++++++
 tb/tb_branch_target_buffer.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/branch_target_buffer.sv
// Two-way set-associative branch target buffer for the IF stage: combinational lookup of the fetch PC,
// registered training from resolved taken branches in writeback, one LRU bit per set.
module branch_target_buffer #(
    parameter int unsigned SETS = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] if_pc,
    input  logic        gl_pred_taken,
    input  logic        wbisbranch,
    input  logic        actual_taken,
    input  logic [15:0] wb_pcplus2,
    input  logic [15:0] wb_target,
    output logic        btb_hit,
    output logic        pred_redirect,
    output logic [15:0] pred_next_pc
);

    localparam int unsigned IW = $clog2(SETS);
    localparam int unsigned TW = 15 - IW;

    typedef logic [TW-1:0] tag_t;

    // Address split shared by the fetch and writeback ports; bit 0 is always zero for word-aligned PCs.
    logic [15:0]   wb_pc;
    logic [IW-1:0] if_idx;
    logic [IW-1:0] wb_idx;
    tag_t          if_tag;
    tag_t          wb_tag;
    logic          unused_pc_lsbs;

    assign wb_pc          = wb_pcplus2 - 16'h2;
    assign if_idx         = if_pc[IW:1];
    assign if_tag         = if_pc[15:IW+1];
    assign wb_idx         = wb_pc[IW:1];
    assign wb_tag         = wb_pc[15:IW+1];
    assign unused_pc_lsbs = if_pc[0] ^ wb_pc[0];

    // Per-way storage. Only valid and LRU bits are reset; tag and target are qualified by valid.
    logic        valid_q  [2][SETS];
    logic        valid_d  [2][SETS];
    tag_t        tag_q    [2][SETS];
    logic [15:0] target_q [2][SETS];
    logic        lru_q    [SETS];
    logic        lru_d    [SETS];

    // Lookup path
    logic        hit0;
    logic        hit1;
    logic [15:0] hit_target;

    assign hit0 = valid_q[0][if_idx] && (tag_q[0][if_idx] == if_tag);
    assign hit1 = valid_q[1][if_idx] && (tag_q[1][if_idx] == if_tag);

    always_comb begin
        hit_target = target_q[1][if_idx];
        if (hit0) begin
            hit_target = target_q[0][if_idx];
        end
    end

    assign btb_hit       = hit0 | hit1;
    assign pred_redirect = btb_hit & gl_pred_taken;
    assign pred_next_pc  = pred_redirect ? hit_target : (if_pc + 16'h2);

    // Update path. There is no handshake: an update presented with wbisbranch && actual_taken
    // is consumed at the next rising edge, and reads in that cycle still see the old contents.
    logic upd_en;
    logic wb_hit0;
    logic wb_hit1;
    logic wb_way;

    assign upd_en  = wbisbranch & actual_taken;
    assign wb_hit0 = valid_q[0][wb_idx] && (tag_q[0][wb_idx] == wb_tag);
    assign wb_hit1 = valid_q[1][wb_idx] && (tag_q[1][wb_idx] == wb_tag);

    always_comb begin
        wb_way = 1'b0;
        if (wb_hit0) begin
            wb_way = 1'b0;
        end else if (wb_hit1) begin
            wb_way = 1'b1;
        end else if (!valid_q[0][wb_idx]) begin
            wb_way = 1'b0;
        end else if (!valid_q[1][wb_idx]) begin
            wb_way = 1'b1;
        end else begin
            wb_way = lru_q[wb_idx];
        end
    end

    always_comb begin
        valid_d = valid_q;
        lru_d   = lru_q;
        if (upd_en) begin
            valid_d[wb_way][wb_idx] = 1'b1;
            lru_d[wb_idx]           = ~wb_way;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[0][s] <= 1'b0;
                valid_q[1][s] <= 1'b0;
                lru_q[s]      <= 1'b0;
            end
        end else begin
            valid_q <= valid_d;
            lru_q   <= lru_d;
        end
    end

    // Rewriting the tag on an update hit stores the value already there, so one write port covers both cases.
    always_ff @(posedge clk) begin
        if (upd_en && !reset) begin
            tag_q[wb_way][wb_idx]    <= wb_tag;
            target_q[wb_way][wb_idx] <= wb_target;
        end
    end

endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed bench for branch_target_buffer: expected {hit, redirect, next_pc} tuples are queued
// as each lookup is driven and popped when the combinational outputs are sampled.
module tb_branch_target_buffer;

    logic        clk;
    logic        reset;
    logic [15:0] if_pc;
    logic        gl_pred_taken;
    logic        wbisbranch;
    logic        actual_taken;
    logic [15:0] wb_pcplus2;
    logic [15:0] wb_target;
    logic        btb_hit;
    logic        pred_redirect;
    logic [15:0] pred_next_pc;

    logic [17:0] exp_q[$];
    int          n_checks;
    int          n_fail;

    branch_target_buffer #(.SETS(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .if_pc        (if_pc),
        .gl_pred_taken(gl_pred_taken),
        .wbisbranch   (wbisbranch),
        .actual_taken (actual_taken),
        .wb_pcplus2   (wb_pcplus2),
        .wb_target    (wb_target),
        .btb_hit      (btb_hit),
        .pred_redirect(pred_redirect),
        .pred_next_pc (pred_next_pc)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver tasks
    task automatic drive_lookup(input logic [15:0] pc, input logic taken);
        if_pc         = pc;
        gl_pred_taken = taken;
    endtask

    task automatic expect_out(input logic hit, input logic redir, input logic [15:0] nxt);
        exp_q.push_back({hit, redir, nxt});
    endtask

    // Scoreboard compare: pops the oldest expectation and checks the live outputs against it.
    task automatic check(input string tag);
        logic [17:0] exp;
        logic [17:0] obs;
        obs = {btb_hit, pred_redirect, pred_next_pc};
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $error("FAIL %s: scoreboard empty, observed %h", tag, obs);
        end else begin
            exp = exp_q.pop_front();
            assert (obs === exp) else begin
                n_fail++;
                $error("FAIL %s: observed hit=%b redir=%b next=%h expected hit=%b redir=%b next=%h",
                       tag, obs[17], obs[16], obs[15:0], exp[17], exp[16], exp[15:0]);
            end
        end
    endtask

    // Lookup during the low phase so the sample is away from the rising edge.
    task automatic lookup(input string tag, input logic [15:0] pc, input logic taken,
                          input logic hit, input logic redir, input logic [15:0] nxt);
        drive_lookup(pc, taken);
        expect_out(hit, redir, nxt);
        @(negedge clk);
        #1;
        check(tag);
    endtask

    task automatic wb_update(input logic [15:0] pcplus2, input logic [15:0] target, input logic taken);
        wbisbranch   = 1'b1;
        actual_taken = taken;
        wb_pcplus2   = pcplus2;
        wb_target    = target;
        @(posedge clk);
        #1;
        wbisbranch   = 1'b0;
        actual_taken = 1'b0;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        logic [15:0] rpc;
        logic        rtk;
        n_checks      = 0;
        n_fail        = 0;
        reset         = 1'b1;
        if_pc         = 16'h3000;
        gl_pred_taken = 1'b1;
        // An update held alongside reset must be dropped.
        wbisbranch    = 1'b1;
        actual_taken  = 1'b1;
        wb_pcplus2    = 16'h3002;
        wb_target     = 16'h1234;
        @(posedge clk);
        #1;
        lookup("in_reset", 16'h3000, 1'b1, 1'b0, 1'b0, 16'h3002);
        @(posedge clk);
        #1;
        wbisbranch   = 1'b0;
        actual_taken = 1'b0;
        reset        = 1'b0;
        lookup("after_reset_miss", 16'h3000, 1'b1, 1'b0, 1'b0, 16'h3002);

        // Learn and predict
        wb_update(16'h3002, 16'h3040, 1'b1);
        lookup("learn_hit_taken", 16'h3000, 1'b1, 1'b1, 1'b1, 16'h3040);
        lookup("learn_hit_nottaken", 16'h3000, 1'b0, 1'b1, 1'b0, 16'h3002);

        // Not-taken writeback is ignored
        wb_update(16'h4002, 16'h4444, 1'b0);
        lookup("nottaken_ignored", 16'h4000, 1'b1, 1'b0, 1'b0, 16'h4002);
        lookup("entry_persists", 16'h3000, 1'b1, 1'b1, 1'b1, 16'h3040);

        // Reset mid-operation discards learned entries
        pulse_reset();
        lookup("midreset_miss", 16'h3000, 1'b1, 1'b0, 1'b0, 16'h3002);

        // Conflict and LRU in set 0
        wb_update(16'h1002, 16'h1100, 1'b1);
        wb_update(16'h2002, 16'h2200, 1'b1);
        wb_update(16'h3002, 16'h3300, 1'b1);
        lookup("lru_1000_evicted", 16'h1000, 1'b1, 1'b0, 1'b0, 16'h1002);
        lookup("lru_2000_hit", 16'h2000, 1'b1, 1'b1, 1'b1, 16'h2200);
        lookup("lru_3000_hit", 16'h3000, 1'b1, 1'b1, 1'b1, 16'h3300);
        wb_update(16'h2002, 16'h2222, 1'b1);
        wb_update(16'h1002, 16'h1111, 1'b1);
        lookup("lru_3000_evicted", 16'h3000, 1'b1, 1'b0, 1'b0, 16'h3002);
        lookup("lru_2000_retrained", 16'h2000, 1'b1, 1'b1, 1'b1, 16'h2222);
        lookup("lru_1000_realloc", 16'h1000, 1'b1, 1'b1, 1'b1, 16'h1111);
        lookup("lru_2000_noredir", 16'h2000, 1'b0, 1'b1, 1'b0, 16'h2002);

        // Same-cycle write and read of the same set: no bypass
        @(negedge clk);
        drive_lookup(16'h5000, 1'b1);
        wbisbranch   = 1'b1;
        actual_taken = 1'b1;
        wb_pcplus2   = 16'h5002;
        wb_target    = 16'h5050;
        expect_out(1'b0, 1'b0, 16'h5002);
        #1;
        check("samecycle_miss");
        @(posedge clk);
        #1;
        wbisbranch   = 1'b0;
        actual_taken = 1'b0;
        lookup("samecycle_next_hit", 16'h5000, 1'b1, 1'b1, 1'b1, 16'h5050);
        // 5000 replaced the LRU way of set 0, which held 2000.
        lookup("set0_2000_evicted", 16'h2000, 1'b1, 1'b0, 1'b0, 16'h2002);
        lookup("set0_1000_kept", 16'h1000, 1'b1, 1'b1, 1'b1, 16'h1111);

        // Wrap-around
        lookup("wrap_miss", 16'hFFFE, 1'b1, 1'b0, 1'b0, 16'h0000);
        wb_update(16'h0000, 16'h0ABC, 1'b1);
        lookup("wrap_trained", 16'hFFFE, 1'b1, 1'b1, 1'b1, 16'h0ABC);
        lookup("wrap_trained_noredir", 16'hFFFE, 1'b0, 1'b1, 1'b0, 16'h0000);

        // Untrained region: tags 0x6xx never written, so every lookup misses.
        for (int i = 0; i < 6; i++) begin
            rpc = {4'h6, 11'($urandom_range(0, 2047)), 1'b0};
            rtk = 1'($urandom_range(0, 1));
            lookup("random_miss", rpc, rtk, 1'b0, 1'b0, rpc + 16'h2);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
